// File: rtl/clock12_pkg.sv
// Shared definitions for the 12-hour clock time-setting controller:
// controller states, edit-field codes and the legal ranges of the time fields.
package clock12_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_E_HR   = 3'd1,
    ST_E_MIN  = 3'd2,
    ST_E_PM   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HR   = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_PM   = 2'd3;

  localparam logic [3:0] HR_MIN  = 4'd1;
  localparam logic [3:0] HR_MAX  = 4'd12;
  localparam logic [5:0] MIN_MIN = 6'd0;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Field code reported to the display for a given controller state.
  function automatic logic [1:0] field_of(input state_e s);
    logic [1:0] f;
    f = FLD_NONE;
    case (s)
      ST_E_HR:  f = FLD_HR;
      ST_E_MIN: f = FLD_MIN;
      ST_E_PM:  f = FLD_PM;
      default:  f = FLD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/clock12_field_step.sv
// Combinational up/down stepper for one time field with wrap-around between
// lo and hi. Up and down together (or neither) leave the value unchanged.
module clock12_field_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] value,
  input  logic         up,
  input  logic         down,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] next_value
);

  // Step the value by one in the requested direction, wrapping at the limits.
  always_comb begin
    next_value = value;
    if (up && !down) begin
      next_value = (value == hi) ? lo : value + W'(1);
    end else if (down && !up) begin
      next_value = (value == lo) ? hi : value - W'(1);
    end
  end

endmodule

// File: rtl/clock12_set_ctrl.sv
// Button-driven time-setting controller for the 12-hour clock counter.
// A session captures the live time into shadow registers, lets the user step
// hours, minutes and AM/PM, then pulses propagate for one cycle so the counter
// loads the edited time. An idle session times out without loading anything.
module clock12_set_ctrl
  import clock12_pkg::*;
#(
  parameter int TIMEOUT_CYC = 30,
  parameter int BLINK_HALF  = 1,
  parameter int TMR_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       cur_PM,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       propagate,
  output logic       out_PM,
  output logic [3:0] out_hours,
  output logic [5:0] out_minutes,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic             propagate_q, propagate_d;
  logic             editing_q, editing_d;
  logic [1:0]       edit_field_q, edit_field_d;
  logic             pm_q, pm_d;
  logic [3:0]       hours_q, hours_d;
  logic [5:0]       minutes_q, minutes_d;

  logic       any_btn;
  logic       hr_up, hr_down, min_up, min_down;
  logic [3:0] hours_step;
  logic [5:0] minutes_step;

  // Mode has priority, so a field only steps when mode is not pressed.
  assign any_btn  = btn_mode | btn_up | btn_down;
  assign hr_up    = (state_q == ST_E_HR)  && !btn_mode && btn_up;
  assign hr_down  = (state_q == ST_E_HR)  && !btn_mode && btn_down;
  assign min_up   = (state_q == ST_E_MIN) && !btn_mode && btn_up;
  assign min_down = (state_q == ST_E_MIN) && !btn_mode && btn_down;

  clock12_field_step #(.W(4)) u_hours_step (
    .value      (hours_q),
    .up         (hr_up),
    .down       (hr_down),
    .lo         (HR_MIN),
    .hi         (HR_MAX),
    .next_value (hours_step)
  );

  clock12_field_step #(.W(6)) u_minutes_step (
    .value      (minutes_q),
    .up         (min_up),
    .down       (min_down),
    .lo         (MIN_MIN),
    .hi         (MIN_MAX),
    .next_value (minutes_step)
  );

  // Session sequencing and the idle timer that aborts a forgotten edit.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      ST_RUN: begin
        if (btn_mode) state_d = ST_E_HR;
      end
      ST_E_HR, ST_E_MIN, ST_E_PM: begin
        if (btn_mode) begin
          case (state_q)
            ST_E_HR:  state_d = ST_E_MIN;
            ST_E_MIN: state_d = ST_E_PM;
            default:  state_d = ST_COMMIT;
          endcase
        end else if (any_btn) begin
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_RUN;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Shadow time: capture the live time on session start, then apply steps.
  always_comb begin
    pm_d      = pm_q;
    hours_d   = hours_step;
    minutes_d = minutes_step;
    if (state_q == ST_RUN && btn_mode) begin
      pm_d      = cur_PM;
      hours_d   = (cur_hours == 4'd0) ? HR_MAX : cur_hours;
      minutes_d = cur_minutes;
    end else if (state_q == ST_E_PM && !btn_mode && (btn_up ^ btn_down)) begin
      pm_d = ~pm_q;
    end
  end

  // Indicator outputs are registered from the next state so they line up with it.
  always_comb begin
    propagate_d  = (state_d == ST_COMMIT);
    editing_d    = (state_d != ST_RUN);
    edit_field_d = field_of(state_d);
    blink_d      = 1'b0;
    blink_cnt_d  = '0;
    if (state_d == ST_RUN) begin
      blink_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      blink_d = 1'b1;
    end else if (blink_cnt_q == BLK_LAST) begin
      blink_d = ~blink_q;
    end else begin
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end
  end

  // All controller state, with asynchronous reset back to the idle clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      timer_q      <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
      propagate_q  <= 1'b0;
      editing_q    <= 1'b0;
      edit_field_q <= FLD_NONE;
      pm_q         <= 1'b0;
      hours_q      <= '0;
      minutes_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
      propagate_q  <= propagate_d;
      editing_q    <= editing_d;
      edit_field_q <= edit_field_d;
      pm_q         <= pm_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
    end
  end

  assign propagate   = propagate_q;
  assign out_PM      = pm_q;
  assign out_hours   = hours_q;
  assign out_minutes = minutes_q;
  assign editing     = editing_q;
  assign edit_field  = edit_field_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_clock12_set_ctrl.sv
// Self-checking bench for clock12_set_ctrl: a session-level model checked on
// every cycle, plus hand-computed expectations at the interesting moments.
module tb_clock12_set_ctrl;

  localparam int TIMEOUT_CYC = 30;
  localparam int BLINK_HALF  = 1;
  localparam int TMR_W       = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       cur_PM = 1'b0;
  logic [3:0] cur_hours = 4'd0;
  logic [5:0] cur_minutes = 6'd0;
  logic       propagate;
  logic       out_PM;
  logic [3:0] out_hours;
  logic [5:0] out_minutes;
  logic       editing;
  logic [1:0] edit_field;
  logic       blink;

  int n_checks = 0;
  int n_errors = 0;
  int prop_seen = 0;
  int prop_before;
  bit check_en = 1'b0;

  // phase: 0 idle clock, 1 hours, 2 minutes, 3 AM/PM, 4 load pulse
  typedef struct {
    int phase;
    int hours;
    int minutes;
    int pm;
    int idle;
    int age;
  } mdl_t;

  mdl_t m;

  always #5 clk = ~clk;

  clock12_set_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .BLINK_HALF  (BLINK_HALF),
    .TMR_W       (TMR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .cur_PM      (cur_PM),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .propagate   (propagate),
    .out_PM      (out_PM),
    .out_hours   (out_hours),
    .out_minutes (out_minutes),
    .editing     (editing),
    .edit_field  (edit_field),
    .blink       (blink)
  );

  function automatic mdl_t stepModel(input mdl_t s, input logic md, input logic u,
                                     input logic d, input logic cpm,
                                     input logic [3:0] ch, input logic [5:0] cm);
    mdl_t n;
    n = s;
    if (s.phase == 0) begin
      if (md) begin
        n.phase = 1;
        n.pm = int'(cpm);
        n.hours = (ch == 4'd0) ? 12 : int'(ch);
        n.minutes = int'(cm);
        n.idle = 0;
      end
    end else if (s.phase == 4) begin
      n.phase = 0;
    end else if (md) begin
      n.phase = s.phase + 1;
      n.idle = 0;
    end else if (u || d) begin
      n.idle = 0;
      if (u != d) begin
        if (s.phase == 1) n.hours = u ? (s.hours % 12) + 1 : ((s.hours + 10) % 12) + 1;
        else if (s.phase == 2) n.minutes = u ? (s.minutes + 1) % 60 : (s.minutes + 59) % 60;
        else n.pm = 1 - s.pm;
      end
    end else begin
      n.idle = s.idle + 1;
      if (n.idle == TIMEOUT_CYC) n.phase = 0;
    end
    if (n.phase == 0 || s.phase == 0) n.age = 0;
    else n.age = s.age + 1;
    return n;
  endfunction

  // Session-level model of the controller.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{default: 0};
    else m <= stepModel(m, btn_mode, btn_up, btn_down, cur_PM, cur_hours, cur_minutes);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc propagate", int'(propagate), (m.phase == 4) ? 1 : 0);
      checkOutput("cyc editing", int'(editing), (m.phase != 0) ? 1 : 0);
      checkOutput("cyc edit_field", int'(edit_field), (m.phase >= 1 && m.phase <= 3) ? m.phase : 0);
      checkOutput("cyc blink", int'(blink),
                  (m.phase != 0 && ((m.age / BLINK_HALF) % 2) == 0) ? 1 : 0);
      checkOutput("cyc out_hours", int'(out_hours), m.hours);
      checkOutput("cyc out_minutes", int'(out_minutes), m.minutes);
      checkOutput("cyc out_PM", int'(out_PM), m.pm);
      if (propagate) prop_seen++;
    end
  end

  task automatic applyStimulus(input logic md, input logic u, input logic d);
    btn_mode = md;
    btn_up   = u;
    btn_down = d;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic setLive(input logic pm, input logic [3:0] h, input logic [5:0] mi);
    cur_PM      = pm;
    cur_hours   = h;
    cur_minutes = mi;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset propagate", int'(propagate), 0);
    checkOutput("reset editing", int'(editing), 0);
    checkOutput("reset edit_field", int'(edit_field), 0);
    checkOutput("reset blink", int'(blink), 0);
    checkOutput("reset hours", int'(out_hours), 0);
    reset = 1'b0;
    check_en = 1'b1;
    idleCycles(2);

    // Start from the post-reset counter value 0:00 AM, then let it time out.
    setLive(1'b0, 4'd0, 6'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1 hours", int'(out_hours), 12);
    checkOutput("t1 minutes", int'(out_minutes), 0);
    checkOutput("t1 pm", int'(out_PM), 0);
    checkOutput("t1 editing", int'(editing), 1);
    checkOutput("t1 field", int'(edit_field), 1);
    checkOutput("t1 blink", int'(blink), 1);
    idleCycles(TIMEOUT_CYC - 1);
    checkOutput("t1 still editing", int'(editing), 1);
    idleCycles(1);
    checkOutput("t1 timed out", int'(editing), 0);
    checkOutput("t1 blink in run", int'(blink), 0);
    #1 checkOutput("t1 no load", prop_seen, 0);

    // A button two cycles before expiry restarts the idle count.
    @(negedge clk);
    setLive(1'b0, 4'd9, 6'd30);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(TIMEOUT_CYC - 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5 hours", int'(out_hours), 10);
    idleCycles(TIMEOUT_CYC - 1);
    checkOutput("t5 still editing", int'(editing), 1);
    idleCycles(1);
    checkOutput("t5 timed out", int'(editing), 0);
    #1 checkOutput("t5 no load", prop_seen, 0);

    // Full session from 11:58 PM to 1:00 AM.
    @(negedge clk);
    setLive(1'b1, 4'd11, 6'd58);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2 capture", int'(out_hours), 11);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2 hr 12", int'(out_hours), 12);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2 hr wrap", int'(out_hours), 1);
    checkOutput("t2 pm kept", int'(out_PM), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2 field min", int'(edit_field), 2);
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2 minutes", int'(out_minutes), 0);
    checkOutput("t2 hours kept", int'(out_hours), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2 field pm", int'(edit_field), 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2 pm toggled", int'(out_PM), 0);
    #1 prop_before = prop_seen;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2 propagate", int'(propagate), 1);
    checkOutput("t2 load hours", int'(out_hours), 1);
    checkOutput("t2 load minutes", int'(out_minutes), 0);
    checkOutput("t2 load pm", int'(out_PM), 0);
    idleCycles(1);
    checkOutput("t2 pulse ended", int'(propagate), 0);
    checkOutput("t2 field none", int'(edit_field), 0);
    checkOutput("t2 hours stable", int'(out_hours), 1);
    #1 checkOutput("t2 one pulse", prop_seen - prop_before, 1);

    // Minutes wrap both ways without touching hours.
    @(negedge clk);
    setLive(1'b0, 4'd3, 6'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3 down wrap", int'(out_minutes), 59);
    checkOutput("t3 hours a", int'(out_hours), 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3 up wrap", int'(out_minutes), 0);
    checkOutput("t3 hours b", int'(out_hours), 3);
    idleCycles(TIMEOUT_CYC);
    checkOutput("t3 timed out", int'(editing), 0);

    // Simultaneous buttons.
    setLive(1'b0, 4'd5, 6'd10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t4 mode wins field", int'(edit_field), 2);
    checkOutput("t4 hours kept", int'(out_hours), 5);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4 up+down min", int'(out_minutes), 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4 up+down pm", int'(out_PM), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4 down pm", int'(out_PM), 1);
    #1 prop_before = prop_seen;
    idleCycles(TIMEOUT_CYC + 1);
    checkOutput("t4 timed out", int'(editing), 0);
    #1 checkOutput("t4 no load", prop_seen - prop_before, 0);

    // Reset during the load pulse.
    @(negedge clk);
    setLive(1'b1, 4'd7, 6'd20);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6 propagate", int'(propagate), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6 propagate drop", int'(propagate), 0);
    checkOutput("t6 editing", int'(editing), 0);
    checkOutput("t6 field", int'(edit_field), 0);
    checkOutput("t6 blink", int'(blink), 0);
    checkOutput("t6 hours", int'(out_hours), 0);
    checkOutput("t6 minutes", int'(out_minutes), 0);
    checkOutput("t6 pm", int'(out_PM), 0);
    @(negedge clk);
    reset = 1'b0;
    idleCycles(2);
    checkOutput("t6 run after", int'(editing), 0);
    checkOutput("t6 no pulse", int'(propagate), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
